// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register,
// and stall/flush event counters for performance inspection.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_IF_ID,
  input  logic             flush_IF,
  input  logic [1:0]       ID_PCSrc,
  input  logic             branch_taken,
  input  logic [31:0]      ID_BranchTarget,
  input  logic [31:0]      ID_JumpTarget,
  input  logic [31:0]      ID_RsData,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IF_PC,
  output logic [31:0]      ID_Inst,
  output logic [31:0]      ID_PC,
  output logic [31:0]      ID_PCPlus4,
  output logic             ID_Valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_REG    = 2'b11;

  logic [31:0]      r_pc;
  logic [31:0]      r_id_inst;
  logic [31:0]      r_id_pc;
  logic [31:0]      r_id_pc_plus4;
  logic             r_id_valid;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_next_pc;
  logic             w_redir;

  assign w_pc_plus4 = r_pc + 32'd4;

  assign w_redir = ((ID_PCSrc == SRC_BRANCH) && branch_taken) ||
                   (ID_PCSrc == SRC_JUMP) || (ID_PCSrc == SRC_REG);

  // Stall is applied in the register enable; this selects the unstalled target.
  always_comb begin
    w_next_pc = w_pc_plus4;
    case (ID_PCSrc)
      SRC_BRANCH: if (branch_taken) w_next_pc = ID_BranchTarget;
      SRC_JUMP:   w_next_pc = ID_JumpTarget;
      SRC_REG:    w_next_pc = {ID_RsData[31:2], 2'b00};
      default:    w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!stall_IF_ID) begin
      r_pc <= w_next_pc;
    end
  end

  // A redirect without flush still latches the fetched word; only flush makes a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_inst     <= 32'd0;
      r_id_pc       <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
      r_id_valid    <= 1'b0;
    end else if (!stall_IF_ID) begin
      if (flush_IF) begin
        r_id_inst     <= 32'd0;
        r_id_pc       <= 32'd0;
        r_id_pc_plus4 <= 32'd0;
        r_id_valid    <= 1'b0;
      end else begin
        r_id_inst     <= imem_rdata;
        r_id_pc       <= r_pc;
        r_id_pc_plus4 <= w_pc_plus4;
        r_id_valid    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (stall_IF_ID) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end else if (flush_IF) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign imem_addr   = r_pc;
  assign IF_PC       = r_pc;
  assign ID_Inst     = r_id_inst;
  assign ID_PC       = r_id_pc;
  assign ID_PCPlus4  = r_id_pc_plus4;
  assign ID_Valid    = r_id_valid;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule
